// File: rtl/clock_gen_pkg.sv
// Shared definitions for the four-phase CPU clock generator.
//   phase_t     : quarter-phase index Q0..Q3 of the processor clock period.
//   *_MASK      : per-phase decode tables, bit N = output value during phase N.
//   PH_RESET    : phase loaded by reset; it decodes to all outputs low, so the
//                 next phase advance lands in Q0 and raises clk.
package clock_gen_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } phase_t;

    // clk is high in Q0,Q1; clk_d (clk delayed a quarter) is high in Q1,Q2.
    // clk_e = clk | clk_d -> Q0..Q2; clk_s = clk & clk_d -> Q1 only.
    localparam logic [3:0] CLK_MASK  = 4'b0011;
    localparam logic [3:0] CLKE_MASK = 4'b0111;
    localparam logic [3:0] CLKS_MASK = 4'b0010;

    localparam phase_t PH_RESET = Q3;

endpackage

// File: rtl/clock_gen_prescaler.sv
// Quarter-phase prescaler: counts sys_clk edges and flags the last edge of
// each quarter-phase.
// Ports:
//   sys_clk : system clock, rising-edge active.
//   reset   : synchronous active-high reset, clears the count.
//   tick    : high while the count sits at PHASE_LEN-1, i.e. the coming edge
//             ends the current quarter-phase.
module clock_gen_prescaler #(
    parameter int PHASE_LEN = 1
) (
    input  logic sys_clk,
    input  logic reset,
    output logic tick
);

    localparam int PW = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1;
    localparam logic [PW-1:0] LAST = PW'(PHASE_LEN - 1);

    logic [PW-1:0] pc;

    assign tick = (pc == LAST);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            pc <= '0;
        end else if (tick) begin
            pc <= '0;
        end else begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/clock_gen.sv
// Four-phase CPU clock generator for the 7-step processor.
// Produces the processor timing signals from the free-running sys_clk; every
// output is a flop loaded from the decode of the next phase, so the outputs
// always equal decode(ph) with no logic after a register.
// Ports:
//   sys_clk : system clock, rising-edge active.
//   reset   : synchronous active-high reset; forces phase Q3, outputs low.
//   clk     : base processor clock, 50% duty.
//   clk_e   : enable clock (clk OR clk_d), 75% duty.
//   clk_s   : set clock (clk AND clk_d), 25% duty, centred inside clk_e.
// Period is 4*PHASE_LEN sys_clk cycles.
module clock_gen
    import clock_gen_pkg::*;
#(
    parameter int PHASE_LEN = 1
) (
    input  logic sys_clk,
    input  logic reset,
    output logic clk,
    output logic clk_e,
    output logic clk_s
);

    logic   tick;
    phase_t ph;
    phase_t ph_next;

    clock_gen_prescaler #(
        .PHASE_LEN(PHASE_LEN)
    ) u_prescaler (
        .sys_clk(sys_clk),
        .reset  (reset),
        .tick   (tick)
    );

    // Next phase: advance one quarter on each prescaler tick, Q3 wraps to Q0.
    always_comb begin
        ph_next = ph;
        if (tick) begin
            ph_next = phase_t'(ph + 2'd1);
        end
    end

    // Phase register and output flops update together from ph_next.
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            ph    <= PH_RESET;
            clk   <= 1'b0;
            clk_e <= 1'b0;
            clk_s <= 1'b0;
        end else begin
            ph    <= ph_next;
            clk   <= CLK_MASK[ph_next];
            clk_e <= CLKE_MASK[ph_next];
            clk_s <= CLKS_MASK[ph_next];
        end
    end

endmodule

// File: tb/tb_clock_gen.sv
// Self-checking bench for clock_gen with PHASE_LEN=1 and PHASE_LEN=3.
module tb_clock_gen;

    logic sys_clk = 1'b0;
    logic reset1  = 1'b1;
    logic reset3  = 1'b1;
    logic clk1, clk_e1, clk_s1;
    logic clk3, clk_e3, clk_s3;

    int compared   = 0;
    int mismatched = 0;

    // expected {clk,clk_e,clk_s} per DUT, pushed before each edge
    logic [2:0] exp1_q[$];
    logic [2:0] exp3_q[$];
    int k1 = 0;   // edges with reset=0 since last reset, PHASE_LEN=1 DUT
    int k3 = 0;   // same for PHASE_LEN=3 DUT
    logic [2:0] obs1, obs3;

    always #5 sys_clk = ~sys_clk;

    clock_gen #(.PHASE_LEN(1)) dut1 (
        .sys_clk(sys_clk), .reset(reset1),
        .clk(clk1), .clk_e(clk_e1), .clk_s(clk_s1)
    );

    clock_gen #(.PHASE_LEN(3)) dut3 (
        .sys_clk(sys_clk), .reset(reset3),
        .clk(clk3), .clk_e(clk_e3), .clk_s(clk_s3)
    );

    // Reference: after k free edges the phase has advanced k/pl times from Q3.
    function automatic logic [2:0] model(input int k, input int pl);
        int ph;
        ph = ((k / pl) + 3) % 4;
        case (ph)
            0:       return 3'b110;
            1:       return 3'b111;
            2:       return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One sys_clk edge: drive resets, push expectations, sample after edge.
    task automatic cycle(input logic r1, input logic r3);
        logic [2:0] e1, e3;
        reset1 = r1;
        reset3 = r3;
        if (r1) k1 = 0; else k1++;
        if (r3) k3 = 0; else k3++;
        exp1_q.push_back(model(k1, 1));
        exp3_q.push_back(model(k3, 3));
        @(posedge sys_clk);
        #1;
        obs1 = {clk1, clk_e1, clk_s1};
        obs3 = {clk3, clk_e3, clk_s3};
        e1 = exp1_q.pop_front();
        e3 = exp3_q.pop_front();
        check("dut1_outputs", 32'(obs1), 32'(e1));
        check("dut3_outputs", 32'(obs3), 32'(e3));
        check("dut1_s_implies_clk", 32'(obs1[0] & ~obs1[2]), 32'd0);
        check("dut1_clk_implies_e", 32'(obs1[2] & ~obs1[1]), 32'd0);
        check("dut3_s_implies_clk", 32'(obs3[0] & ~obs3[2]), 32'd0);
        check("dut3_clk_implies_e", 32'(obs3[2] & ~obs3[1]), 32'd0);
    endtask

    initial begin
        logic [7:0] t_clk, t_e, t_s;
        int n_c1, n_e1, n_s1, n_c3, n_e3, n_s3, n;
        t_clk = 8'b11001100;
        t_e   = 8'b11101110;
        t_s   = 8'b01000100;

        // Reset hold from unknown state
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b1);
            check("reset_hold_dut1", 32'(obs1), 32'd0);
            check("reset_hold_dut3", 32'(obs3), 32'd0);
        end

        // PHASE_LEN=1 directed sequence after release
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0);
            check("seq_clk",   32'(obs1[2]), 32'(t_clk[7-i]));
            check("seq_clk_e", 32'(obs1[1]), 32'(t_e[7-i]));
            check("seq_clk_s", 32'(obs1[0]), 32'(t_s[7-i]));
        end

        // Duty sweep
        n_c1 = 0; n_e1 = 0; n_s1 = 0; n_c3 = 0; n_e3 = 0; n_s3 = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 1'b0);
            n_c1 += int'(obs1[2]); n_e1 += int'(obs1[1]); n_s1 += int'(obs1[0]);
            if (i < 396) begin
                n_c3 += int'(obs3[2]); n_e3 += int'(obs3[1]); n_s3 += int'(obs3[0]);
            end
        end
        check("duty1_clk",   32'(n_c1), 32'd200);
        check("duty1_clk_e", 32'(n_e1), 32'd300);
        check("duty1_clk_s", 32'(n_s1), 32'd100);
        check("duty3_clk",   32'(n_c3), 32'd198);
        check("duty3_clk_e", 32'(n_e3), 32'd297);
        check("duty3_clk_s", 32'(n_s3), 32'd99);

        // PHASE_LEN=3 latency: reset once, count edges to first clk rise
        cycle(1'b0, 1'b1);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0);
            n++;
            if (obs3[2]) break;
        end
        check("dut3_first_rise", 32'(n), 32'd3);

        // Mid-cycle reset on dut1 while in Q1
        n = 0;
        while (obs1 != 3'b111 && n < 8) begin
            cycle(1'b0, 1'b0);
            n++;
        end
        check("dut1_reached_q1", 32'(obs1), 32'b111);
        cycle(1'b1, 1'b0);
        check("midreset_outputs", 32'(obs1), 32'd0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0);
            check("restart_clk",   32'(obs1[2]), 32'(t_clk[7-i]));
            check("restart_clk_e", 32'(obs1[1]), 32'(t_e[7-i]));
            check("restart_clk_s", 32'(obs1[0]), 32'(t_s[7-i]));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
